windower_serial_ctrl: RTL and testbench

- Frame sequencer for the serial windower.
- On a start request it pulses the windower's serial-phase reset, then streams one full frame of serialized beats from a synchronous source RAM, applying downstream hold when asserted.
- After the last beat it drains the windower until output goes quiet, then reports completion, the number of output windows and a frame count.
- Sits between the frame-buffer RAM and windower_serial_ramin; the RAM data bus goes straight to the windower's data_in, and this block owns only address, enables and valids.

---
 rtl/windower_serial_ctrl.sv | 159 +++++++++++++++
 tb/tb_windower_serial_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/windower_serial_ctrl.sv
// Frame sequencer for the serial windower: primes the windower, streams one frame of beats from
// the source RAM, drains until output goes quiet, then reports. Optional stall counter: WIN_CTRL_PERF_EN.
module windower_serial_ctrl #(
    parameter  int LOG2_IMG_SIZE = 5,
    parameter  int SER_CYC       = 4,
    parameter  int FLUSH_CYC     = 20,
    parameter  int CNT_W         = 16,
    localparam int ADDR_W        = LOG2_IMG_SIZE + $clog2(SER_CYC),
    localparam int BEATS         = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              win_vld,
    output logic              win_ser_rst,
    input  logic              win_vld_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  out_cnt,
`ifdef WIN_CTRL_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int FL_W = $clog2(FLUSH_CYC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic               win_vld_q;
    logic               ser_rst_q;
    logic               busy_q;
    logic               done_q;
    logic [FL_W-1:0]    flush_q;
    logic [CNT_W-1:0]   win_cnt_q;
    logic [CNT_W-1:0]   win_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q;
    logic [CNT_W-1:0]   frame_cnt_q;

    // Read strobe follows hold directly so a stall takes effect in the same cycle.
    assign rd_en = (state_q == S_STREAM) && !hold;

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (win_vld_out && (win_cnt_q != {CNT_W{1'b1}})) begin
            win_cnt_d = win_cnt_q + CNT_W'(1);
        end
    end

`ifdef WIN_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (hold && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == S_PRIME) begin
            stall_q <= '0;
        end else if (state_q == S_STREAM) begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            win_vld_q   <= 1'b0;
            ser_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            flush_q     <= '0;
            win_cnt_q   <= '0;
            out_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            // The RAM has one cycle of read latency, so valid trails the read strobe.
            win_vld_q <= rd_en;
            ser_rst_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_PRIME;
                        ser_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                S_PRIME: begin
                    state_q   <= S_STREAM;
                    rd_addr_q <= '0;
                    win_cnt_q <= CNT_W'(win_vld_out);
                end
                S_STREAM: begin
                    win_cnt_q <= win_cnt_d;
                    if (!hold) begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                        if (rd_addr_q == ADDR_W'(BEATS - 1)) begin
                            state_q <= S_FLUSH;
                            flush_q <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    win_cnt_q <= win_cnt_d;
                    if (win_vld_out) begin
                        flush_q <= '0;
                    end else if (flush_q == FL_W'(FLUSH_CYC - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        flush_q <= flush_q + FL_W'(1);
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    out_cnt_q   <= win_cnt_q;
                    frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr     = rd_addr_q;
    assign win_vld     = win_vld_q;
    assign win_ser_rst = ser_rst_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign out_cnt     = out_cnt_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_windower_serial_ctrl.sv
// Testbench for windower_serial_ctrl: table-driven frame scenarios, a mid-frame reset sequence
// and random frames, all checked cycle by cycle against a frame-level reference model.
module tb_windower_serial_ctrl;

    localparam int LOG2_IMG_SIZE = 5;
    localparam int SER_CYC       = 4;
    localparam int FLUSH_CYC     = 20;
    localparam int CNT_W         = 16;
    localparam int ADDR_W        = 7;
    localparam int BEATS         = 128;
    localparam int MAXC          = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              hold;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              win_vld;
    logic              win_ser_rst;
    logic              win_vld_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  out_cnt;
    logic [CNT_W-1:0]  frame_cnt;
`ifdef WIN_CTRL_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    windower_serial_ctrl #(
        .LOG2_IMG_SIZE(LOG2_IMG_SIZE),
        .SER_CYC      (SER_CYC),
        .FLUSH_CYC    (FLUSH_CYC),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .hold       (hold),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .win_vld    (win_vld),
        .win_ser_rst(win_ser_rst),
        .win_vld_out(win_vld_out),
        .busy       (busy),
        .done       (done),
        .out_cnt    (out_cnt),
`ifdef WIN_CTRL_PERF_EN
        .stall_cnt  (stall_cnt),
`endif
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Stimulus per frame cycle (cycle 1 = PRIME) and the model's expected trace.
    bit                h [MAXC];
    bit                v [MAXC];
    bit                e_rd   [MAXC];
    bit                e_wv   [MAXC];
    bit                e_srst [MAXC];
    bit                e_busy [MAXC];
    bit                e_done [MAXC];
    logic [ADDR_W-1:0] e_addr [MAXC];
    int                m_done;
    int                m_wins;
    int                m_stalls;
    logic [CNT_W-1:0]  exp_out;
    logic [CNT_W-1:0]  exp_frames;

    typedef struct {
        string name;
        int    hold_at;
        int    hold_len;
        int    v_first;
        int    v_stride;
        int    v_count;
        bit    keep_start;
        int    exp_done;
        int    exp_out;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, act, exp);
        end
    endtask

    // Frame-level model: reads happen on non-held stream cycles until BEATS have been issued,
    // then the frame ends after FLUSH_CYC consecutive quiet drain cycles.
    task automatic build_model();
        int reads;
        int quiet;
        int c;
        int last_rd;
        for (int i = 0; i < MAXC; i++) begin
            e_rd[i] = 0; e_wv[i] = 0; e_srst[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_addr[i] = '0;
        end
        m_stalls = 0;
        m_wins = 0;
        e_srst[1] = 1;
        reads = 0;
        c = 2;
        while (reads < BEATS) begin
            e_addr[c] = ADDR_W'(reads);
            e_rd[c] = !h[c];
            if (h[c]) m_stalls++;
            else reads++;
            c++;
        end
        last_rd = c - 1;
        quiet = 0;
        m_done = MAXC - 2;
        for (int k = last_rd + 1; k < MAXC - 2; k++) begin
            quiet = v[k] ? 0 : quiet + 1;
            if (quiet == FLUSH_CYC) begin
                m_done = k + 1;
                break;
            end
        end
        for (int k = 1; k <= m_done; k++) e_busy[k] = 1;
        e_done[m_done] = 1;
        for (int k = 1; k <= m_done + 1; k++) e_wv[k] = e_rd[k-1];
        for (int k = 1; k < m_done; k++) m_wins += int'(v[k]);
    endtask

    task automatic run_frame(input string name, input bit keep_start, output int done_cyc, output int srst_cnt);
        logic [43:0] act;
        logic [43:0] exp;
        build_model();
        done_cyc = -1;
        srst_cnt = 0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= m_done + 1; c++) begin
            #2;
            hold = h[c];
            win_vld_out = v[c];
            start = keep_start;
            @(negedge clk);
            act = {rd_en, rd_addr, win_vld, win_ser_rst, busy, done, out_cnt, frame_cnt};
            exp = {e_rd[c], e_addr[c], e_wv[c], e_srst[c], e_busy[c], e_done[c], exp_out, exp_frames};
            check({name, "_cyc"}, c, {20'd0, act}, {20'd0, exp});
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (win_ser_rst === 1'b1) srst_cnt++;
            if (c == m_done) begin
                exp_out = CNT_W'(m_wins);
                exp_frames = exp_frames + CNT_W'(1);
            end
`ifdef WIN_CTRL_PERF_EN
            if (c == m_done + 1) check({name, "_stall"}, c, 64'(stall_cnt), 64'(m_stalls));
`endif
            if (c <= m_done) @(posedge clk);
        end
    endtask

    task automatic set_pattern(input vec_t t);
        for (int c = 0; c < MAXC; c++) begin
            h[c] = (c >= t.hold_at) && (c < t.hold_at + t.hold_len);
            v[c] = 0;
        end
        for (int k = 0; k < t.v_count; k++) v[t.v_first + k * t.v_stride] = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int sc;
        int srst_pair;
        bit found;

        tbl[0] = '{"basic",     0,  0, 0,  1, 0,  1'b0, 150, 0};
        tbl[1] = '{"hold40",    42, 5, 0,  1, 0,  1'b0, 155, 0};
        tbl[2] = '{"drain",     0,  0, 15, 4, 32, 1'b0, 160, 32};
        tbl[3] = '{"startheld", 0,  0, 0,  1, 0,  1'b1, 150, 0};
        tbl[4] = '{"pulse64a",  0,  0, 3,  2, 64, 1'b1, 150, 64};
        tbl[5] = '{"pulse64b",  0,  0, 3,  2, 64, 1'b0, 150, 64};

        rst = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        win_vld_out = 1'b0;
        exp_out = '0;
        exp_frames = '0;
        #3;
        check("reset_state", 0,
              {20'd0, rd_en, rd_addr, win_vld, win_ser_rst, busy, done, out_cnt, frame_cnt}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        srst_pair = 0;
        for (int i = 0; i < 6; i++) begin
            set_pattern(tbl[i]);
            run_frame(tbl[i].name, tbl[i].keep_start, dc, sc);
            check({tbl[i].name, "_done_cyc"}, dc, 64'(dc), 64'(tbl[i].exp_done));
            check({tbl[i].name, "_out_cnt"}, dc, 64'(out_cnt), 64'(tbl[i].exp_out));
            check({tbl[i].name, "_primes"}, dc, 64'(sc), 64'd1);
            if (i >= 4) srst_pair += sc;
        end
        check("b2b_frame_cnt", 0, 64'(frame_cnt), 64'd6);
        check("b2b_ser_rst_pulses", 0, 64'(srst_pair), 64'd2);

        // Reset in the middle of a frame, then a clean frame from address 0.
        start = 1'b1;
        hold = 1'b0;
        win_vld_out = 1'b0;
        @(posedge clk);
        #2 start = 1'b0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rd_en === 1'b1 && rd_addr == ADDR_W'(60)) begin
                found = 1;
                break;
            end
        end
        check("rst_wait_addr60", 0, 64'(found), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", 0,
              {20'd0, rd_en, rd_addr, win_vld, win_ser_rst, busy, done, out_cnt, frame_cnt}, 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        exp_out = '0;
        exp_frames = '0;
        for (int c = 0; c < MAXC; c++) begin h[c] = 0; v[c] = 0; end
        run_frame("after_rst", 1'b0, dc, sc);
        check("after_rst_frame_cnt", dc, 64'(frame_cnt), 64'd1);

        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < MAXC; c++) begin
                h[c] = (c < 300) && ($urandom_range(0, 3) == 0);
                v[c] = (c >= 1) && (c < 300) && ($urandom_range(0, 7) == 0);
            end
            run_frame("random", 1'($urandom_range(0, 1)), dc, sc);
            check("random_primes", dc, 64'(sc), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
